// File: rtl/a2d_spi_master_pkg.sv
// a2d_pkg: shared types, field positions and command builder for the ADC128S SPI reader
package a2d_pkg;
  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP, DONE} a2d_state_t;
  localparam int CMD_CH_MSB = 13;
  localparam int CMD_CH_LSB = 11;
  localparam int RES_W = 12;
  localparam int FRAME_BITS_DEF = 16;
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    logic [15:0] c;
    c = '0;
    c[CMD_CH_MSB:CMD_CH_LSB] = ch;
    return c;
  endfunction
endpackage

// File: rtl/a2d_spi_master_if.sv
// a2d_spi_master_if: request/result handshake plus ADC pins; master = SPI initiator side, slave = sequencer/ADC side
interface a2d_spi_master_if;
  import a2d_pkg::*;
  logic strt_cnv;
  logic [2:0] chnnl;
  logic cnv_cmplt;
  logic [RES_W-1:0] res;
  logic busy;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  modport master(input strt_cnv, chnnl, MISO, output cnv_cmplt, res, busy, SS_n, SCLK, MOSI);
  modport slave(output strt_cnv, chnnl, MISO, input cnv_cmplt, res, busy, SS_n, SCLK, MOSI);
endinterface

// File: rtl/a2d_spi_master_spi_shift16.sv
// spi_shift16: 16-bit TX shifter, RX capture and bit counter (ports: load/cmd reload, shift_tx, sample_rx, miso in; mosi, rx_data, done16 out)
module spi_shift16 #(
  parameter int NB = 16,
  parameter int RW = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [15:0] cmd,
  input  logic shift_tx,
  input  logic sample_rx,
  input  logic miso,
  output logic mosi,
  output logic [RW-1:0] rx_data,
  output logic done16
);
  logic [15:0] tx;
  logic [4:0] bits;
  // RX is only RW wide: the leading frame bits fall off the top, which drops the unused upper result bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx <= '0;
      rx_data <= '0;
      bits <= '0;
    end else if (load) begin
      tx <= cmd;
      rx_data <= '0;
      bits <= '0;
    end else begin
      if (shift_tx) tx <= {tx[14:0], 1'b0};
      if (sample_rx) begin
        rx_data <= {rx_data[RW-2:0], miso};
        bits <= bits + 5'd1;
      end
    end
  assign mosi = tx[15];
  assign done16 = bits == 5'(NB);
endmodule

// File: rtl/a2d_spi_master.sv
// a2d_spi_master: two-frame SPI read of one ADC128S channel (clk, rst_n; bus: strt_cnv/chnnl in, res/cnv_cmplt/busy out, SS_n/SCLK/MOSI/MISO pins)
module a2d_spi_master import a2d_pkg::*; #(
  parameter int SCLK_DIV = 32,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int GAP_CLKS = 32
) (
  input logic clk,
  input logic rst_n,
  a2d_spi_master_if.master bus
);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int GW = $clog2(GAP_CLKS) + 1;
  localparam logic [DW-1:0] HALF = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] HALF_M1 = DW'(SCLK_DIV / 2 - 1);
  a2d_state_t state, nxt;
  logic [DW-1:0] div, nxt_div;
  logic [GW-1:0] gap, nxt_gap;
  logic lead, frame, ss_n, sclk, load, shift_tx, sample_rx, mosi, done16, cnv_cmplt;
  logic [2:0] ch;
  logic [15:0] ld_cmd;
  logic [RES_W-1:0] rx, res;
  spi_shift16 #(.NB(FRAME_BITS), .RW(RES_W)) u_shift (
    .clk(clk), .rst_n(rst_n), .load(load), .cmd(ld_cmd), .shift_tx(shift_tx),
    .sample_rx(sample_rx), .miso(bus.MISO), .mosi(mosi), .rx_data(rx), .done16(done16)
  );
  // the falling edge entering SHIFT (lead) already presents cmd[15], so it does not shift
  assign shift_tx = state == SHIFT && div == '0 && !lead;
  assign sample_rx = state == SHIFT && div == HALF;
  always_comb begin
    nxt = state;
    nxt_div = div;
    nxt_gap = gap;
    load = 1'b0;
    ld_cmd = a2d_cmd(ch);
    case (state)
      IDLE: if (bus.strt_cnv) begin
        nxt = FRONT;
        nxt_div = '0;
        load = 1'b1;
        ld_cmd = a2d_cmd(bus.chnnl);
      end
      FRONT: begin
        nxt_div = div == HALF_M1 ? '0 : div + 1'b1;
        nxt = div == HALF_M1 ? SHIFT : FRONT;
      end
      // stay through the high half of the last bit so each frame spans whole SCLK periods
      SHIFT: begin
        nxt_div = div + 1'b1;
        nxt = done16 && div == '1 ? BACK : SHIFT;
      end
      BACK: begin
        nxt_div = div == HALF_M1 ? '0 : div + 1'b1;
        nxt_gap = '0;
        nxt = div != HALF_M1 ? BACK : frame ? DONE : GAP;
      end
      GAP: begin
        nxt_gap = gap + 1'b1;
        load = gap == GW'(GAP_CLKS - 1);
        nxt = load ? FRONT : GAP;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // pins are registered from next-state values so they line up with the state without glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      gap <= '0;
      lead <= 1'b0;
      frame <= 1'b0;
      ch <= '0;
      ss_n <= 1'b1;
      sclk <= 1'b1;
      cnv_cmplt <= 1'b0;
      res <= '0;
    end else begin
      state <= nxt;
      div <= nxt_div;
      gap <= nxt_gap;
      lead <= nxt == SHIFT && state != SHIFT;
      ss_n <= !(nxt inside {FRONT, SHIFT, BACK});
      sclk <= nxt != SHIFT || nxt_div[DW-1];
      if (state == IDLE && bus.strt_cnv) begin
        ch <= bus.chnnl;
        frame <= 1'b0;
        cnv_cmplt <= 1'b0;
      end
      if (state == GAP && nxt == FRONT) frame <= 1'b1;
      if (state == DONE) begin
        res <= rx;
        cnv_cmplt <= 1'b1;
      end
    end
  assign bus.SS_n = ss_n;
  assign bus.SCLK = sclk;
  assign bus.MOSI = mosi;
  assign bus.cnv_cmplt = cnv_cmplt;
  assign bus.res = res;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_a2d_spi_master.sv
// tb_a2d_spi_master: directed bench with an ADC128S pin model for a2d_spi_master
module tb_a2d_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  a2d_spi_master_if bus();
  a2d_spi_master dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int pass_n = 0;
  int total_n = 0;
  logic [11:0] vals [8];
  int miso_mode = 0;
  int rises = 0, falls = 0, bad_sclk = 0, busy_lo = 0;
  logic [15:0] mosi_w = '0, resp_w = '0;
  logic [2:0] addr = '0;
  time t_first = 0, t_last = 0, t_ssr = 0;
  logic [15:0] q_mosi[$];
  int q_rises[$], q_falls[$];
  time q_per[$], q_gap[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic clr();
    q_mosi.delete(); q_rises.delete(); q_falls.delete(); q_per.delete(); q_gap.delete();
  endtask
  // issues strt_cnv now (just after an edge) and counts edges until cnv_cmplt; optional extra pulse at edge poke
  task automatic run(input logic [2:0] c, input int poke, input logic [2:0] pc, output int lat);
    bus.strt_cnv = 1'b1;
    bus.chnnl = c;
    lat = 0;
    busy_lo = 0;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      bus.strt_cnv = lat == poke;
      if (lat == poke) bus.chnnl = pc;
      if (lat < 1121 && !bus.busy) busy_lo++;
      if (bus.cnv_cmplt) break;
    end
    bus.strt_cnv = 1'b0;
  endtask
  always @(negedge bus.SS_n) begin
    if (t_ssr != 0) q_gap.push_back($time - t_ssr);
    rises = 0; falls = 0; mosi_w = '0;
    resp_w = {4'h0, vals[addr]};
  end
  always @(posedge bus.SS_n) begin
    t_ssr = $time;
    q_mosi.push_back(mosi_w); q_rises.push_back(rises); q_falls.push_back(falls);
    q_per.push_back(t_last - t_first);
    addr = mosi_w[13:11];
  end
  always @(negedge bus.SCLK) if (!bus.SS_n) begin
    bus.MISO = miso_mode == 1 ? 1'b1 : miso_mode == 2 ? 1'b0 : falls < 16 ? resp_w[15 - falls] : 1'b0;
    falls++;
  end
  always @(posedge bus.SCLK) if (!bus.SS_n) begin
    if (rises == 0) t_first = $time;
    t_last = $time;
    mosi_w = {mosi_w[14:0], bus.MOSI};
    rises++;
  end
  always @(bus.SCLK) if (bus.SS_n && rst_n) bad_sclk++;
  initial begin
    int lat;
    logic [15:0] w;
    vals = '{12'h3C1, 12'h7E2, 12'h0F4, 12'h8A7, 12'h19B, 12'hA5C, 12'h6D0, 12'hB38};
    bus.strt_cnv = 1'b0; bus.chnnl = '0; bus.MISO = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ss_n", bus.SS_n, 1); chk("rst_sclk", bus.SCLK, 1); chk("rst_mosi", bus.MOSI, 0);
    chk("rst_cmplt", bus.cnv_cmplt, 0); chk("rst_res", bus.res, 0); chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
    run(3'd5, -1, 3'd0, lat);
    chk("t1_latency", lat, 1122); chk("t1_res", bus.res, 12'hA5C); chk("t1_frames", q_mosi.size(), 2);
    chk("t1_mosi_f1", q_mosi[0], 16'h2800); chk("t1_mosi_f2", q_mosi[1], 16'h2800);
    chk("t1_rises", q_rises[1], 16); chk("t1_falls", q_falls[1], 16);
    chk("t1_sclk_15per", 32'(q_per[1]), 4800); chk("t1_gap", 32'(q_gap[$]), 320); chk("t1_busy", busy_lo, 0);
    repeat (20) @(posedge clk); #1;
    chk("t1_cmplt_hold", bus.cnv_cmplt, 1); chk("t1_res_hold", bus.res, 12'hA5C);
    for (int c = 0; c < 8; c++) begin
      clr();
      run(3'(c), -1, 3'd0, lat);
      chk($sformatf("sweep_res_ch%0d", c), bus.res, vals[c]);
      w = q_mosi[0]; chk($sformatf("sweep_ch_f1_%0d", c), w[13:11], c);
      w = q_mosi[1]; chk($sformatf("sweep_ch_f2_%0d", c), w[13:11], c);
    end
    clr();
    run(3'd6, 200, 3'd2, lat);
    chk("ign_latency", lat, 1122); chk("ign_res", bus.res, vals[6]);
    chk("ign_frames", q_mosi.size(), 2); chk("ign_busy", busy_lo, 0);
    clr();
    run(3'd7, 1120, 3'd0, lat);
    chk("done_res", bus.res, vals[7]);
    repeat (5) @(posedge clk); #1;
    chk("done_poke_busy", bus.busy, 0); chk("done_poke_frames", q_mosi.size(), 2);
    bus.strt_cnv = 1'b1; bus.chnnl = 3'd4;
    @(posedge clk); #1;
    bus.strt_cnv = 1'b0;
    repeat (859) @(posedge clk);
    #3;
    chk("rst_mid_in_frame", bus.SS_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_ss_n", bus.SS_n, 1); chk("mrst_sclk", bus.SCLK, 1); chk("mrst_mosi", bus.MOSI, 0);
    chk("mrst_cmplt", bus.cnv_cmplt, 0); chk("mrst_res", bus.res, 0); chk("mrst_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(3'd1, -1, 3'd0, lat);
    chk("post_rst_latency", lat, 1122); chk("post_rst_res", bus.res, vals[1]);
    miso_mode = 1;
    @(posedge clk); #1;
    run(3'd3, -1, 3'd0, lat);
    chk("miso_ones", bus.res, 12'hFFF);
    miso_mode = 2;
    @(posedge clk); #1;
    run(3'd3, -1, 3'd0, lat);
    chk("miso_zeros", bus.res, 12'h000);
    chk("sclk_idle_toggles", bad_sclk, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/a2d_spi_master.md
Name: a2d_spi_master

Overview:
SPI initiator that reads one channel of the ADC128S 8-channel A2D, which digitizes the slide potentiometers that set the equalizer band gains. On a start pulse it runs two 16-bit SPI frames, then presents the 12-bit result with a completion flag. The first frame addresses the channel and the second returns that channel's conversion. It sits between the equalizer's gain-update sequencer and the A2D pins (A2D_SS_n, A2D_SCLK, A2D_MOSI, A2D_MISO).

Parameters:
SCLK_DIV, 32, clk cycles per SCLK period; must be a power of 2 and at least 8
FRAME_BITS, 16, SCLK periods per SS_n-low frame
GAP_CLKS, 32, clk cycles SS_n is held high between frame 1 and frame 2

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
strt_cnv  in  1  one-cycle start request; sampled only in IDLE
chnnl  in  3  A2D channel 0-7; captured on the accepted strt_cnv
MISO  in  1  serial data from A2D
SS_n  out  1  active-low slave select
SCLK  out  1  serial clock; idles high (mode 3)
MOSI  out  1  serial data to A2D, MSB first
cnv_cmplt  out  1  result valid; high from frame-2 end until next accepted strt_cnv
res  out  12  conversion result (second frame bits [11:0])
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, busy=0, state IDLE. Reset is asynchronous and may assert mid-frame. All outputs return to reset values immediately. No partial result is retained.
- Command word: cmd = {2'b00, chnnl, 11'h000}, so channel sits in bits [13:11]. cmd is loaded into the TX shift register at the start of both frames.
- States: IDLE, FRONT, SHIFT, BACK, GAP, DONE.
- IDLE: on strt_cnv=1, capture chnnl, clear cnv_cmplt, drive SS_n=0, set frame=0, go to FRONT.
- FRONT: SCLK high for SCLK_DIV/2 clks, with MOSI = cmd[15]. Go to SHIFT.
- SHIFT: SCLK = MSB of a log2(SCLK_DIV)-bit divider counter.
  - Falling SCLK on counter wrap to 0: first edge of each frame does nothing; later edges shift TX left and drive MOSI with the new MSB.
  - Rising SCLK when counter reaches SCLK_DIV/2: shift MISO into the RX LSB and increment the bit count.
  - After the 16th rising edge, go to BACK.
- BACK: SCLK held high for SCLK_DIV/2 clks, then SS_n=1.
  - If frame=0: go to GAP.
  - If frame=1: go to DONE.
- GAP: SS_n high for GAP_CLKS clks, then SS_n=0, frame=1, reload TX with cmd, go to FRONT.
- DONE: one cycle. res <= rx[11:0], cnv_cmplt <= 1, go to IDLE. rx[15:12] are ignored.
- Total latency from strt_cnv to cnv_cmplt: 2*(16*SCLK_DIV + SCLK_DIV) + GAP_CLKS + 2 clks. With defaults this is 1122.
- Boundary rules:
  - strt_cnv while busy is ignored; chnnl changes while busy have no effect.
  - strt_cnv in the same cycle DONE completes is ignored, because the state is not yet IDLE.
  - Frame-1 RX data is discarded.
  - MOSI is only guaranteed meaningful while SS_n=0.
  - SCLK never toggles while SS_n=1.

Decomposition:
- Package a2d_pkg:
  - state enum a2d_state_t
  - CMD_CH_MSB=13, CMD_CH_LSB=11
  - RES_W=12, FRAME_BITS default
- One sub-module, spi_shift16. It holds the 16-bit TX/RX shift registers and the bit counter, with inputs load, shift_tx, sample_rx and miso, and outputs mosi, rx_data and done16. The FSM and SCLK divider stay in a2d_spi_master.

Test Plan:
- Reset, then chnnl=3'd5 with a 1-clk strt_cnv -> per frame: SS_n low, 16 SCLK falls and 16 rises, SCLK period 32 clks. MOSI during bits 15..0 = 16'h2800. SS_n high 32 clks between frames.
- ADC128S model returns channel-5 value 12'hA5C -> cnv_cmplt rises exactly 1122 clks after strt_cnv, with res=12'hA5C. cnv_cmplt stays high until the next strt_cnv.
- Sweep chnnl 0..7 back-to-back, with strt_cnv issued on the first IDLE cycle after each completion -> each res matches the model value for that channel. MOSI channel field equals chnnl in both frames.
- Pulse strt_cnv with chnnl=2 at clk 200 of an active chnnl=6 conversion -> no extra frames, res is the channel-6 value, busy stays continuously high.
- Assert rst_n=0 during frame-2 bit 7 -> SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=0 immediately. A new strt_cnv after release completes normally.
- Hold MISO=1 throughout -> res=12'hFFF. Hold MISO=0 -> res=12'h000.
